// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the serial-bus round-robin arbiter.
package bus_arbiter_pkg;

  localparam int unsigned N_REQ_DEF    = 4;
  localparam int unsigned XFER_LEN_DEF = 8;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_PRE  = 2'd1;
  localparam logic [1:0] ENC_XFER = 2'd2;
  localparam logic [1:0] ENC_GAP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_PRE  = ENC_PRE,
    ST_XFER = ENC_XFER,
    ST_GAP  = ENC_GAP
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward
// from last+1 with wrap-around.
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // k = N_REQ revisits last itself, so a lone re-request still wins
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_i) + k) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared serial bus: grants one write_sm at a time,
// announces the load cycle (bs_bsy_pre) and times the fixed-length transfer.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned XFER_LEN = XFER_LEN_DEF,
  parameter int unsigned IDX_W    = idx_width(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            bs_rqst,
  output logic [N_REQ-1:0]            bs_gnt,
  output logic [IDX_W-1:0]            bs_sel,
  output logic                        bs_bsy_pre,
  output logic                        bs_bsy,
  output logic                        bs_abort,
  output logic [$clog2(XFER_LEN)-1:0] xfer_cnt
);

  localparam int unsigned CNT_W = $clog2(XFER_LEN);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_last_q, rr_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (bs_rqst),
    .last_i  (rr_last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rr_last_q <= IDX_W'(N_REQ - 1);
      cnt_q     <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    abort_d    = abort_q;
    bs_gnt     = '0;
    bs_sel     = '0;
    bs_bsy_pre = 1'b0;
    bs_bsy     = 1'b0;
    bs_abort   = 1'b0;
    xfer_cnt   = '0;

    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        if (state_q == ST_GAP) begin
          bs_abort = abort_q;
        end
        abort_d = 1'b0;
        cnt_d   = '0;
        if (pick_valid) begin
          idx_d     = pick_idx;
          rr_last_d = pick_idx;
          state_d   = ST_PRE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE: begin
        bs_gnt     = N_REQ'(1) << idx_q;
        bs_sel     = idx_q;
        bs_bsy_pre = 1'b1;
        cnt_d      = '0;
        if (bs_rqst[idx_q]) begin
          state_d = ST_XFER;
        end else begin
          abort_d = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_XFER: begin
        bs_gnt   = N_REQ'(1) << idx_q;
        bs_sel   = idx_q;
        bs_bsy   = 1'b1;
        xfer_cnt = cnt_q;
        // a dropped request wins over reaching the last bit
        if (!bs_rqst[idx_q]) begin
          abort_d = 1'b1;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_W'(XFER_LEN - 1)) begin
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised plus directed scoreboard bench for bus_arbiter.
module tb_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned L  = 8;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  bs_rqst = '0;
  logic [N-1:0]  bs_gnt;
  logic [IW-1:0] bs_sel;
  logic          bs_bsy_pre, bs_bsy, bs_abort;
  logic [CW-1:0] xfer_cnt;

  bus_arbiter #(.N_REQ(N), .XFER_LEN(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .bs_rqst    (bs_rqst),
    .bs_gnt     (bs_gnt),
    .bs_sel     (bs_sel),
    .bs_bsy_pre (bs_bsy_pre),
    .bs_bsy     (bs_bsy),
    .bs_abort   (bs_abort),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [IW-1:0] sel;
    logic          pre;
    logic          bsy;
    logic          abort;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: who owns the bus and how many cycles since the grant.
  int owner     = -1;
  int age       = 0;
  bit in_gap    = 1'b0;
  bit gap_abort = 1'b0;
  int last      = N - 1;

  function automatic obs_t model_out();
    obs_t e;
    e = '0;
    if (owner >= 0 && !in_gap) begin
      e.gnt = N'(1) << owner;
      e.sel = IW'(owner);
      e.pre = (age == 0);
      e.bsy = (age > 0);
      e.cnt = (age > 0) ? CW'(age - 1) : '0;
    end else if (in_gap) begin
      e.abort = gap_abort;
    end
    return e;
  endfunction

  task automatic model_step(input logic [N-1:0] r);
    int c;
    if (owner >= 0 && !in_gap) begin
      if (!r[owner[IW-1:0]]) begin
        in_gap = 1'b1; gap_abort = 1'b1;
      end else if (age == L) begin
        in_gap = 1'b1; gap_abort = 1'b0;
      end else begin
        age++;
      end
    end else begin
      in_gap = 1'b0; gap_abort = 1'b0; owner = -1;
      for (int k = 1; k <= N; k++) begin
        c = (last + k) % N;
        if (owner < 0 && r[c[IW-1:0]]) owner = c;
      end
      if (owner >= 0) begin
        last = owner;
        age  = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: advances on every clock edge, resets asynchronously.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        owner = -1; age = 0; in_gap = 1'b0; gap_abort = 1'b0; last = N - 1;
        exp_q.delete();
        if (clk) exp_q.push_back('0);
      end else begin
        model_step(bs_rqst);
        exp_q.push_back(model_out());
      end
    end
  end

  // Monitor: one expected observation per cycle, compared mid-cycle.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bs_gnt, bs_sel, bs_bsy_pre, bs_bsy, bs_abort, xfer_cnt};
        if (e.gnt == '0) begin
          a.sel = '0;
          e.sel = '0;
        end
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle t=%0t: got gnt=%b sel=%0d pre=%b bsy=%b abort=%b cnt=%0d expected gnt=%b sel=%0d pre=%b bsy=%b abort=%b cnt=%0d",
                   $time, a.gnt, a.sel, a.pre, a.bsy, a.abort, a.cnt,
                   e.gnt, e.sel, e.pre, e.bsy, e.abort, e.cnt);
        end
        n_checks++;
        if ($countones(bs_gnt) > 1) begin
          n_fail++;
          $display("FAIL onehot t=%0t: got gnt=%b expected at most one bit", $time, bs_gnt);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] was_gnt;
    logic [N-1:0] r;
    bit found;

    cyc(3);
    rst = 1'b0;

    // idle stability
    cyc(20);

    // single request, dropped in GAP
    bs_rqst = 4'b0001;
    cyc(1);
    chk("single_gnt", 32'(bs_gnt), 32'h1);
    chk("single_pre", 32'(bs_bsy_pre), 32'h1);
    cyc(9);
    chk("single_gap_abort", 32'(bs_abort), 32'h0);
    chk("single_gap_bsy", 32'(bs_bsy), 32'h0);
    bs_rqst = '0;
    cyc(3);

    // full contention, five grants
    bs_rqst = 4'b1111;
    cyc(50);
    bs_rqst = '0;
    cyc(3);

    // fairness wrap: req2 then 0101 twice
    bs_rqst = 4'b0100;
    cyc(10);
    bs_rqst = 4'b0101;
    cyc(1);
    chk("wrap_first", 32'(bs_gnt), 32'h1);
    cyc(10);
    chk("wrap_second", 32'(bs_sel), 32'h2);
    cyc(9);
    bs_rqst = '0;
    cyc(3);

    // early drop at bit 3
    bs_rqst = 4'b0010;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (bs_bsy && xfer_cnt == 3'd3) found = 1'b1;
    end
    chk("early_drop_reached", 32'(found), 32'h1);
    bs_rqst = '0;
    cyc(1);
    chk("early_drop_abort", 32'(bs_abort), 32'h1);
    cyc(3);

    // drop during PRE
    bs_rqst = 4'b0010;
    cyc(1);
    chk("pre_drop_pre", 32'(bs_bsy_pre), 32'h1);
    bs_rqst = '0;
    cyc(1);
    chk("pre_drop_abort", 32'(bs_abort), 32'h1);
    chk("pre_drop_bsy", 32'(bs_bsy), 32'h0);
    cyc(3);

    // async reset mid-transfer
    bs_rqst = 4'b0100;
    cyc(4);
    #1 rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(bs_gnt), 32'h0);
    chk("arst_bsy", 32'(bs_bsy), 32'h0);
    chk("arst_cnt", 32'(xfer_cnt), 32'h0);
    chk("arst_abort", 32'(bs_abort), 32'h0);
    bs_rqst = 4'b1111;
    #2 rst = 1'b0;
    cyc(1);
    chk("arst_first_gnt", 32'(bs_gnt), 32'h1);
    cyc(19);
    bs_rqst = '0;
    cyc(3);

    // randomised requesters
    was_gnt = bs_gnt;
    r = bs_rqst;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if (bs_gnt[i] && $urandom_range(0, 39) == 0) r[i] = 1'b0;
          else if (was_gnt[i] && !bs_gnt[i]) r[i] = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 5) == 0) begin
          r[i] = 1'b1;
        end
      end
      was_gnt = bs_gnt;
      bs_rqst = r;
      cyc(1);
    end
    bs_rqst = '0;
    cyc(15);
    chk("queue_drained", 32'(exp_q.size() <= 1), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter that shares the single serial output bus between N_REQ write state machines. Each requester raises bs_rqst. The arbiter grants one requester at a time, drives the bus data-select mux index, and times the fixed-length serial transfer. It issues bs_bsy_pre one cycle ahead of bs_bsy so the granted write_sm can load its parallel-to-serial register.

Parameters:
N_REQ, 4, number of requesters (write state machines); must be ≥2.
XFER_LEN, 8, bus cycles per transfer (serialized word length); must be ≥2.
IDX_W, $clog2(N_REQ), width of the grant index / mux select.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
bs_rqst  input  N_REQ  per-requester bus request; held high until the transfer ends.
bs_gnt  output  N_REQ  one-hot grant, high during PRE and XFER.
bs_sel  output  IDX_W  index of the current grantee; drives the bus data-select mux.
bs_bsy_pre  output  1  high only in PRE, one cycle before bs_bsy.
bs_bsy  output  1  high for every XFER cycle.
bs_abort  output  1  one-cycle pulse when a grantee drops its request early.
xfer_cnt  output  $clog2(XFER_LEN)  bit position of the current transfer (0..XFER_LEN-1); 0 outside XFER.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_last=N_REQ-1, bs_gnt=0, bs_sel=0, bs_bsy_pre=0, bs_bsy=0, bs_abort=0, xfer_cnt=0, abort flag=0. Requester 0 has top priority after reset.
- Moore outputs: every output decodes only from registered state, idx, cnt and abort flag. No combinational path from bs_rqst to any output.
- States: IDLE, PRE, XFER, GAP (2-bit encoding).
- IDLE: if bs_rqst≠0, pick the winner by scanning from (rr_last+1) mod N_REQ upward with wrap. Latch idx=winner and rr_last=winner, then go to PRE. Otherwise stay in IDLE.
- PRE (1 cycle): bs_gnt=onehot(idx), bs_sel=idx, bs_bsy_pre=1.
  - If bs_rqst[idx]=1, go to XFER with cnt=0.
  - If bs_rqst[idx]=0, set the abort flag and go to GAP.
- XFER: bs_gnt and bs_sel held, bs_bsy=1, xfer_cnt=cnt.
  - If bs_rqst[idx]=0, set the abort flag and go to GAP. Abort takes precedence over completion.
  - Else if cnt==XFER_LEN-1, go to GAP with no abort.
  - Else cnt increments.
- GAP (1 turnaround cycle): bs_gnt=0, bs_bsy=0, bs_abort=abort flag, and the flag clears on exit. GAP arbitrates exactly like IDLE: on a pending request it goes directly to PRE, otherwise to IDLE.
- Timing: a request sampled at edge E gives grant and bs_bsy_pre in cycle E+1. bs_bsy is high in cycles E+2..E+1+XFER_LEN. GAP follows. Back-to-back service period is XFER_LEN+2 cycles.
- Simultaneous requests: only one grant ever. No requester waits more than N_REQ-1 transfers while its request stays high.
- A new request arriving during PRE/XFER/GAP does not disturb the current grant; it is sampled at the next arbitration point.
- A grantee that re-requests in GAP is not re-granted while any other request is pending (round-robin from rr_last+1).
- Mid-operation reset: all outputs drop asynchronously to their reset values, the transfer is discarded, and no bs_abort is issued.

Decomposition:
- Shared package: state enum (IDLE/PRE/XFER/GAP) and encoding localparams, N_REQ/XFER_LEN defaults, IDX_W derivation.
- Sub-module rr_pick (combinational): inputs req[N_REQ-1:0] and last[IDX_W-1:0]; outputs valid and idx. Reused by both IDLE and GAP.
- Top level holds the FSM, counter and registers.

Test Plan:
- Single request (defaults): rst released, bs_rqst=0001 held at edge E → bs_gnt=0001 and bs_bsy_pre=1 in E+1; bs_bsy=1 with xfer_cnt 0..7 in E+2..E+9; GAP in E+10 with bs_abort=0; IDLE in E+11 if the request has dropped.
- Contention: bs_rqst=1111 held → grants 0,1,2,3,0 in order, each grant 9 cycles, period 10 cycles, never two bits of bs_gnt high.
- Fairness wrap: after a req2 transfer, bs_rqst=0101 → req0 granted (scan 3,0). A following 0101 → req2 granted, bs_sel=2.
- Early drop: grantee 1 drops bs_rqst at xfer_cnt=3 → next cycle is GAP, bs_bsy=0, bs_abort=1 for exactly 1 cycle. Drop during PRE → bs_bsy never rises, bs_abort=1.
- Async reset: rst pulsed for 3 ns mid-XFER (not clock-aligned) → bs_gnt, bs_bsy and xfer_cnt read 0 before the next clk edge. After release, 1111 → requester 0 granted first.
- Idle stability: bs_rqst=0 for 20 cycles → all outputs stay 0 and state stays IDLE.
